// File: rtl/vga_rgb_fetch_if.sv
// SRAM read port and VGA colour bundle shared by the RGB fetch block and its environment.
// Latency: none (wires only).
// Backpressure: none; reads are flow-controlled inside the fetch block by FIFO credit.
interface vga_rgb_fetch_if;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [9:0]  VGA_red;
    logic [9:0]  VGA_green;
    logic [9:0]  VGA_blue;

    modport master (
        output SRAM_address,
        output SRAM_we_n,
        output VGA_red,
        output VGA_green,
        output VGA_blue,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_we_n,
        input  VGA_red,
        input  VGA_green,
        input  VGA_blue,
        output SRAM_read_data
    );
endinterface

// File: rtl/vga_rgb_fetch.sv
// Prefetches packed RGB words from SRAM into a small FIFO and unpacks them into VGA colours.
// Latency: SRAM read 3 clocks to FIFO; colour registered 1 clock after the new-pixel event.
// Backpressure: reads issued only while FIFO level + in-flight < depth; empty FIFO gives black + sticky underflow.
module vga_rgb_fetch #(
    parameter logic [17:0] RGB_BASE    = 18'd146944,
    parameter logic [16:0] IMG_WORDS   = 17'd115200,
    parameter int          VIEW_LEFT   = 160,
    parameter int          VIEW_RIGHT  = 480,
    parameter int          VIEW_TOP    = 120,
    parameter int          VIEW_BOTTOM = 360,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                   CLOCK_50_I,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [9:0]             pixel_X_pos,
    input  logic [9:0]             pixel_Y_pos,
    vga_rgb_fetch_if.master        bus,
    output logic [3:0]             fifo_level,
    output logic                   underflow
);
    // Pointers wrap naturally, so FIFO_DEPTH is expected to be a power of two.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] X_LO   = 10'(VIEW_LEFT);
    localparam logic [9:0] X_HI   = 10'(VIEW_RIGHT);
    localparam logic [9:0] Y_LO   = 10'(VIEW_TOP);
    localparam logic [9:0] Y_END  = 10'(VIEW_BOTTOM);
    localparam logic [9:0] Y_LAST = 10'(VIEW_BOTTOM - 1);

    logic [17:0]   addr_q, addr_d;
    logic [16:0]   wcnt_q, wcnt_d;
    logic [2:0]    infl_q, infl_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [3:0]    level_q, level_d;
    logic [7:0]    r1_q, r1_d;
    logic [9:0]    x_prev_q, x_prev_d, y_prev_q, y_prev_d;
    logic [9:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          uf_q, uf_d;

    logic          new_pix, in_view, restart, push, issue, pop_evt, pop_ok;
    logic [3:0]    infl_cnt, need, pop_n;
    logic [4:0]    credit_used;
    logic [15:0]   w_a, w_b;

    // Fetch issue, FIFO push/pop, pixel unpacking and frame restart.
    always_comb begin
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        r1_d     = r1_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        uf_d     = uf_q;
        x_prev_d = pixel_X_pos;
        y_prev_d = pixel_Y_pos;

        new_pix  = (pixel_X_pos != x_prev_q);
        in_view  = (pixel_X_pos >= X_LO) && (pixel_X_pos < X_HI) &&
                   (pixel_Y_pos >= Y_LO) && (pixel_Y_pos < Y_END);
        restart  = (pixel_Y_pos == Y_END) && (y_prev_q == Y_LAST);

        // Oldest in-flight read lands this edge.
        push        = infl_q[2];
        infl_cnt    = 4'(infl_q[0]) + 4'(infl_q[1]) + 4'(infl_q[2]);
        credit_used = 5'(level_q) + 5'(infl_cnt);
        issue       = enable && (credit_used < 5'(FIFO_DEPTH)) && (wcnt_q < IMG_WORDS);

        pop_evt  = enable && new_pix && in_view;
        need     = pixel_X_pos[0] ? 4'd1 : 4'd2;
        pop_ok   = pop_evt && (level_q >= need);
        pop_n    = pop_ok ? need : 4'd0;
        w_a      = mem_q[rd_ptr_q];
        w_b      = mem_q[rd_ptr_q + PW'(1)];

        if (!enable || !in_view) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end else if (new_pix) begin
            if (!pop_ok) begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
                uf_d    = 1'b1;
            end else if (!pixel_X_pos[0]) begin
                // Even pixel: {R0,G0},{B0,R1}; keep R1 for the odd partner.
                red_d    = {w_a[15:8], 2'b00};
                green_d  = {w_a[7:0], 2'b00};
                blue_d   = {w_b[15:8], 2'b00};
                r1_d     = w_b[7:0];
                rd_ptr_d = rd_ptr_q + PW'(2);
            end else begin
                // Odd pixel: held R1 plus {G1,B1}.
                red_d    = {r1_q, 2'b00};
                green_d  = {w_a[15:8], 2'b00};
                blue_d   = {w_a[7:0], 2'b00};
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = bus.SRAM_read_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        level_d = level_q + 4'(push) - pop_n;

        if (issue) begin
            addr_d = RGB_BASE + 18'(wcnt_q);
            wcnt_d = wcnt_q + 17'd1;
        end
        infl_d = {infl_q[1:0], issue};

        // Frame restart discards everything queued or in flight and rewinds the image.
        if (restart) begin
            addr_d   = addr_q;
            wcnt_d   = '0;
            infl_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            uf_d     = 1'b0;
        end
    end

    // State registers; reset drops in-flight reads so late SRAM data is ignored.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= RGB_BASE;
            wcnt_q   <= '0;
            infl_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            r1_q     <= '0;
            x_prev_q <= '0;
            y_prev_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            uf_q     <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            infl_q   <= infl_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            r1_q     <= r1_d;
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            uf_q     <= uf_d;
        end
    end

    assign bus.SRAM_address = addr_q;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.VGA_red      = red_q;
    assign bus.VGA_green    = green_q;
    assign bus.VGA_blue     = blue_q;
    assign fifo_level       = level_q;
    assign underflow        = uf_q;
endmodule

// File: tb/tb_vga_rgb_fetch.sv
// Bench for vga_rgb_fetch: 3-clock model SRAM, colour scoreboard, reduced-width frame scan.
// Latency: colour expected one clock after each driven pixel.
// Backpressure: none from the bench; FIFO credit is observed through fifo_level.
module tb_vga_rgb_fetch;
    localparam logic [17:0] BASE  = 18'd146944;
    localparam int          W     = 16;
    localparam logic [16:0] WORDS = 17'd5760;   // 240 lines * 16 pixels * 1.5 words

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [9:0] px, py;
    logic [3:0] lvl;
    logic       uf;

    always #5 clk = ~clk;

    vga_rgb_fetch_if bus();

    vga_rgb_fetch #(
        .RGB_BASE(BASE), .IMG_WORDS(WORDS),
        .VIEW_LEFT(160), .VIEW_RIGHT(160 + W), .VIEW_TOP(120), .VIEW_BOTTOM(360),
        .FIFO_DEPTH(8)
    ) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .enable     (enable),
        .pixel_X_pos(px),
        .pixel_Y_pos(py),
        .bus        (bus),
        .fifo_level (lvl),
        .underflow  (uf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, want);
    endtask

    function automatic logic [15:0] sram_word(input logic [17:0] a);
        logic [17:0] off;
        off = a - BASE;
        case (off)
            18'd0:   return 16'h1122;
            18'd1:   return 16'h3344;
            18'd2:   return 16'h5566;
            default: return {a[7:0] ^ 8'hA5, a[15:8] + a[7:0] + 8'h17};
        endcase
    endfunction

    // Model SRAM: address seen after edge k is answered in time for edge k+3.
    logic [17:0] a0 = BASE, a1 = BASE, a2 = BASE, last_addr = BASE;
    int          chg = 0;
    always @(negedge clk) begin
        a2 = a1;
        a1 = a0;
        a0 = bus.SRAM_address;
        bus.SRAM_read_data = sram_word(a2);
        if (bus.SRAM_address !== last_addr) chg++;
        last_addr = bus.SRAM_address;
    end

    function automatic logic [29:0] rgb();
        return {bus.VGA_red, bus.VGA_green, bus.VGA_blue};
    endfunction

    // Expected colour of visible pixel p (raster order) from the packed image.
    function automatic logic [29:0] exp_pix(input int p);
        int          w;
        logic [15:0] x0, x1, x2;
        w = 3 * (p / 2);
        if (p % 2 == 0) begin
            x0 = sram_word(BASE + 18'(w));
            x1 = sram_word(BASE + 18'(w + 1));
            return {x0[15:8], 2'b00, x0[7:0], 2'b00, x1[15:8], 2'b00};
        end
        x1 = sram_word(BASE + 18'(w + 1));
        x2 = sram_word(BASE + 18'(w + 2));
        return {x1[7:0], 2'b00, x2[15:8], 2'b00, x2[7:0], 2'b00};
    endfunction

    logic [29:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix_step(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic check_out, input logic [29:0] e);
        px = x;
        py = y;
        if (check_out) sb.push_back(e);
        tick();
        if (check_out) chk(tag, 32'(rgb()), 32'(sb.pop_front()));
    endtask

    localparam logic [29:0] PIX0 = {10'h044, 10'h088, 10'h0CC};
    localparam logic [29:0] PIX1 = {10'h110, 10'h154, 10'h198};

    int chg_base;

    initial begin
        resetn = 1'b0; enable = 1'b0; px = '0; py = '0;
        repeat (3) tick();
        chk("rst_addr", 32'(bus.SRAM_address), 32'(BASE));
        chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("rst_rgb", 32'(rgb()), 32'd0);
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_uf", 32'(uf), 32'd0);

        // Prefetch burst with a static position.
        resetn = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fill_addr", 32'(bus.SRAM_address), 32'(BASE) + 32'(i));
        end
        tick();
        chk("fill_stop", 32'(bus.SRAM_address), 32'(BASE) + 32'd7);
        tick();
        chk("fill_lvl7", 32'(lvl), 32'd7);
        tick();
        chk("fill_lvl8", 32'(lvl), 32'd8);
        chk("fill_stop2", 32'(bus.SRAM_address), 32'(BASE) + 32'd7);

        pix_step("outside_rgb", 10'd100, 10'd120, 1'b1, 30'd0);
        chk("outside_lvl", 32'(lvl), 32'd8);
        pix_step("pix160", 10'd160, 10'd120, 1'b1, PIX0);
        chk("pop2_lvl", 32'(lvl), 32'd6);
        pix_step("pix160_hold", 10'd160, 10'd120, 1'b1, PIX0);
        pix_step("pix161", 10'd161, 10'd120, 1'b1, PIX1);
        pix_step("pix500", 10'd500, 10'd120, 1'b1, 30'd0);
        chk("no_uf", 32'(uf), 32'd0);

        // Enable rises as X enters the window with an empty FIFO.
        resetn = 1'b0; enable = 1'b0; px = 10'd159; py = 10'd120;
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        chk("en0_lvl", 32'(lvl), 32'd0);
        enable = 1'b1;
        pix_step("uf_rgb", 10'd160, 10'd120, 1'b1, 30'd0);
        chk("uf_set", 32'(uf), 32'd1);
        repeat (12) tick();
        chk("uf_sticky", 32'(uf), 32'd1);
        chk("refill_lvl", 32'(lvl), 32'd8);

        // Leave 3 reads in flight on the last visible line, then restart.
        pix_step("l359_out", 10'd500, 10'd359, 1'b1, 30'd0);
        pix_step("l359_p0", 10'd160, 10'd359, 1'b1, PIX0);
        pix_step("l359_hold", 10'd160, 10'd359, 1'b0, 30'd0);
        pix_step("l359_p1", 10'd161, 10'd359, 1'b1, PIX1);
        pix_step("l359_hold", 10'd161, 10'd359, 1'b0, 30'd0);
        chk("uf_hold", 32'(uf), 32'd1);
        pix_step("restart_rgb", 10'd500, 10'd360, 1'b1, 30'd0);
        chk("restart_lvl", 32'(lvl), 32'd0);
        chk("restart_uf", 32'(uf), 32'd0);
        chk("restart_noissue", 32'(bus.SRAM_address), 32'(BASE) + 32'd10);
        tick();
        chk("restart_addr", 32'(bus.SRAM_address), 32'(BASE));
        chk("discard_lvl1", 32'(lvl), 32'd0);
        tick();
        chk("discard_lvl2", 32'(lvl), 32'd0);
        tick();
        chk("discard_lvl3", 32'(lvl), 32'd0);
        tick();
        chk("restart_push", 32'(lvl), 32'd1);

        // Reset with reads outstanding; their data must never reach the FIFO.
        resetn = 1'b0; px = 10'd500; py = 10'd119;
        tick();
        resetn = 1'b1;
        chg_base = chg;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_lvl", 32'(lvl), 32'd0);
        end
        tick();
        chk("abort_push", 32'(lvl), 32'd1);
        repeat (10) tick();

        // Whole (reduced-width) frame.
        for (int r = 0; r < 240; r++) begin
            for (int c = 0; c < W; c++) begin
                pix_step("scan_pix", 10'(160 + c), 10'(120 + r), 1'b1, exp_pix(r * W + c));
                pix_step("scan_hold", 10'(160 + c), 10'(120 + r), 1'b0, 30'd0);
            end
            px = 10'd500;
            repeat (4) tick();
        end
        repeat (10) tick();
        chk("scan_reads", 32'(chg - chg_base), 32'(WORDS) - 32'd1);
        chk("scan_last", 32'(bus.SRAM_address), 32'(BASE) + 32'(WORDS) - 32'd1);
        chk("scan_uf", 32'(uf), 32'd0);
        chk("scan_lvl", 32'(lvl), 32'd0);
        repeat (10) tick();
        chk("no_wrap", 32'(bus.SRAM_address), 32'(BASE) + 32'(WORDS) - 32'd1);
        chk("no_wrap_reads", 32'(chg - chg_base), 32'(WORDS) - 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
